// File: rtl/uart_tx_fifo_drain.sv
// ============================================================================
// uart_tx_fifo_drain
// ----------------------------------------------------------------------------
// Purpose:
//   UART transmitter placed directly behind a show-ahead transmit FIFO. While
//   the FIFO is not empty it pops one word and serialises it LSB-first as
//   start / DBIT data / optional parity / stop. After the frame it fetches the
//   next word. A free-running divider produces the 16x oversampling baud tick.
//   Frames can run back to back with a single idle-high cycle between them.
//
// Parameters:
//   DBIT     data bits per frame (5..8)
//   SB_TICK  stop-bit length in baud ticks (16 = 1, 24 = 1.5, 32 = 2 bits)
//   DVSR     clk cycles per baud tick
//   DVSR_W   width of the baud divisor counter (2**DVSR_W >= DVSR)
//   PAR_EN   1 = append a parity bit after the data bits
//   PAR_ODD  1 = odd parity, 0 = even parity
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_i         asynchronous, active-high reset
//   fifo_empty_i  FIFO empty flag
//   fifo_data_i   FIFO head word, valid while fifo_empty_i = 0
//   fifo_rd_o     FIFO pop strobe, high only during the fetch cycle
//   tx_o          serial line, idle high, registered
//   tx_busy_o     high from the fetch cycle through the last stop-bit cycle
//   tx_done_o     one-cycle pulse after the stop bit completes, registered
// ============================================================================
module uart_tx_fifo_drain #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16,
    parameter int unsigned DVSR    = 163,
    parameter int unsigned DVSR_W  = 8,
    parameter bit          PAR_EN  = 1'b0,
    parameter bit          PAR_ODD = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            fifo_empty_i,
    input  logic [DBIT-1:0] fifo_data_i,
    output logic            fifo_rd_o,
    output logic            tx_o,
    output logic            tx_busy_o,
    output logic            tx_done_o
);

    // The tick counter must reach both 15 (one bit) and SB_TICK-1 (stop).
    localparam int unsigned S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int unsigned N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [DVSR_W-1:0] B_LAST = DVSR_W'(DVSR - 1);
    localparam logic [DVSR_W-1:0] B_ZERO = DVSR_W'(0);
    localparam logic [DVSR_W-1:0] B_ONE  = DVSR_W'(1);
    localparam logic [S_W-1:0]    S_LAST = S_W'(15);
    localparam logic [S_W-1:0]    S_STOP = S_W'(SB_TICK - 1);
    localparam logic [S_W-1:0]    S_ZERO = S_W'(0);
    localparam logic [S_W-1:0]    S_ONE  = S_W'(1);
    localparam logic [N_W-1:0]    N_LAST = N_W'(DBIT - 1);
    localparam logic [N_W-1:0]    N_ZERO = N_W'(0);
    localparam logic [N_W-1:0]    N_ONE  = N_W'(1);
    localparam logic [DBIT-1:0]   D_ZERO = DBIT'(0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity over the data word; even parity is plain XOR, odd inverts it.
    function automatic logic calc_parity(input logic [DBIT-1:0] data);
        calc_parity = (^data) ^ PAR_ODD;
    endfunction

    logic [DVSR_W-1:0] baud_q, baud_d;
    logic              tick_s;
    state_t            state_q, state_d;
    logic [S_W-1:0]    s_q, s_d;
    logic [N_W-1:0]    n_q, n_d;
    logic [DBIT-1:0]   shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              fetch_s;

    // ------------------------------------------------------------------------
    // Baud generator: free-running, never restarted by the frame logic, so
    // the first tick after a fetch lands anywhere within one divisor period.
    // ------------------------------------------------------------------------
    assign tick_s = (baud_q == B_LAST);

    // Divisor next-count: wrap to zero on the tick cycle.
    always_comb begin
        if (tick_s) begin
            baud_d = B_ZERO;
        end else begin
            baud_d = baud_q + B_ONE;
        end
    end

    // Divisor register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            baud_q <= B_ZERO;
        end else begin
            baud_q <= baud_d;
        end
    end

    // ------------------------------------------------------------------------
    // Fetch: the FIFO is show-ahead, so the pop strobe has to coincide with
    // the cycle in which the head word is latched. It is therefore decoded
    // from the registered state rather than registered itself; reset masks
    // it so a pending word is never popped while the block is held in reset.
    // ------------------------------------------------------------------------
    assign fetch_s   = (state_q == ST_IDLE) && !fifo_empty_i && !rst_i;
    assign fifo_rd_o = fetch_s;
    assign tx_busy_o = (state_q != ST_IDLE) || fetch_s;
    assign tx_o      = tx_q;
    assign tx_done_o = done_q;

    // State, tick/bit counters and data registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            s_q     <= S_ZERO;
            n_q     <= N_ZERO;
            shift_q <= D_ZERO;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: advance one bit every 16 ticks, stop after SB_TICK.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fetch_s) begin
                    shift_d = fifo_data_i;
                    par_d   = calc_parity(fifo_data_i);
                    s_d     = S_ZERO;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    if (s_q == S_LAST) begin
                        s_d     = S_ZERO;
                        n_d     = N_ZERO;
                        state_d = ST_DATA;
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    if (s_q == S_LAST) begin
                        s_d     = S_ZERO;
                        shift_d = {1'b0, shift_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = PAR_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            n_d = n_q + N_ONE;
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick_s) begin
                    if (s_q == S_LAST) begin
                        s_d     = S_ZERO;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    if (s_q == S_STOP) begin
                        s_d     = S_ZERO;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                s_d     = S_ZERO;
                n_d     = N_ZERO;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level follows the state being entered, so tx changes on the same
    // edge as the state register (fetch-to-falling-edge latency of one cycle).
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// ============================================================================
// tb_uart_tx_fifo_drain
// ----------------------------------------------------------------------------
// Four instances share clock and reset:
//   0: 8N1, 1 stop      1: even parity      2: odd parity      3: 2 stop bits
// A frame-level model predicts every output on every cycle from the fetch
// time and the tick phase; a trace of one watched tx line is decoded like a
// receiver would to pin the model with hand-computed values.
// ============================================================================
module tb_uart_tx_fifo_drain;

    localparam int DV    = 4;
    localparam int NI    = 4;
    localparam int BIT_C = 16 * DV;
    localparam int SAMP  = BIT_C + BIT_C / 2 - 2;
    localparam int PEN [NI] = '{0, 1, 1, 0};
    localparam int POD [NI] = '{0, 0, 1, 0};
    localparam int SBT [NI] = '{16, 16, 16, 32};

    logic          clk = 1'b0;
    logic          rst;
    logic [NI-1:0] empty;
    logic [7:0]    fdat [NI];
    logic          rd_a, tx_a, busy_a, done_a;
    logic          rd_b, tx_b, busy_b, done_b;
    logic          rd_c, tx_c, busy_c, done_c;
    logic          rd_d, tx_d, busy_d, done_d;
    logic [NI-1:0] rd_v, tx_v, busy_v, done_v;

    assign rd_v   = {rd_d, rd_c, rd_b, rd_a};
    assign tx_v   = {tx_d, tx_c, tx_b, tx_a};
    assign busy_v = {busy_d, busy_c, busy_b, busy_a};
    assign done_v = {done_d, done_c, done_b, done_a};

    always #5 clk = ~clk;

    uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(16), .DVSR(DV), .DVSR_W(3), .PAR_EN(1'b0), .PAR_ODD(1'b0)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .fifo_empty_i(empty[0]), .fifo_data_i(fdat[0]),
        .fifo_rd_o(rd_a), .tx_o(tx_a), .tx_busy_o(busy_a), .tx_done_o(done_a));
    uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(16), .DVSR(DV), .DVSR_W(3), .PAR_EN(1'b1), .PAR_ODD(1'b0)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .fifo_empty_i(empty[1]), .fifo_data_i(fdat[1]),
        .fifo_rd_o(rd_b), .tx_o(tx_b), .tx_busy_o(busy_b), .tx_done_o(done_b));
    uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(16), .DVSR(DV), .DVSR_W(3), .PAR_EN(1'b1), .PAR_ODD(1'b1)) u_dut_c (
        .clk_i(clk), .rst_i(rst), .fifo_empty_i(empty[2]), .fifo_data_i(fdat[2]),
        .fifo_rd_o(rd_c), .tx_o(tx_c), .tx_busy_o(busy_c), .tx_done_o(done_c));
    uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(32), .DVSR(DV), .DVSR_W(3), .PAR_EN(1'b0), .PAR_ODD(1'b0)) u_dut_d (
        .clk_i(clk), .rst_i(rst), .fifo_empty_i(empty[3]), .fifo_data_i(fdat[3]),
        .fifo_rd_o(rd_d), .tx_o(tx_d), .tx_busy_o(busy_d), .tx_done_o(done_d));

    int         vec_cnt = 0;
    int         err_cnt = 0;
    int         cyc = 0;
    logic [7:0] fq [NI][$];
    bit         m_busy [NI];
    int         m_st_end [NI];
    int         m_fr_end [NI];
    int         m_done [NI];
    int         m_nb [NI];
    logic [8:0] m_bits [NI];
    logic [NI-1:0] rd_seen;
    int         watch = 0;
    logic       tr [$];
    int         rd_cnt = 0;
    int         done_idx [$];

    task automatic chk(input string nm, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NI; k++) begin
            m_busy[k] = 1'b0;
            m_done[k] = -1;
        end
    endtask

    // Frame-level prediction for one instance in the current cycle.
    task automatic model_cycle(input int k);
        int   e_tx, e_rd, e_busy, e_done, t0, j;
        logic par;
        e_done = (m_done[k] == cyc) ? 1 : 0;
        e_tx = 1; e_rd = 0; e_busy = 0;
        if (rst) begin
            e_done = 0;
        end else if (!m_busy[k] && fq[k].size() != 0) begin
            e_rd = 1; e_busy = 1;
            t0 = cyc + 1;
            while (t0 % DV != DV - 1) t0++;
            par = ^fq[k][0];
            if (POD[k] != 0) par = ~par;
            m_bits[k]   = {par, fq[k][0]};
            m_nb[k]     = 8 + PEN[k];
            m_st_end[k] = t0 + 15 * DV;
            m_fr_end[k] = m_st_end[k] + BIT_C * m_nb[k] + SBT[k] * DV;
            m_busy[k]   = 1'b1;
        end else if (m_busy[k]) begin
            e_busy = 1;
            if (cyc <= m_st_end[k]) begin
                e_tx = 0;
            end else if (cyc <= m_st_end[k] + BIT_C * m_nb[k]) begin
                j = (cyc - m_st_end[k] - 1) / BIT_C;
                e_tx = m_bits[k][j];
            end
            if (cyc == m_fr_end[k]) begin
                m_busy[k] = 1'b0;
                m_done[k] = cyc + 1;
            end
        end
        chk($sformatf("tx[%0d]", k), tx_v[k], e_tx);
        chk($sformatf("fifo_rd[%0d]", k), rd_v[k], e_rd);
        chk($sformatf("tx_busy[%0d]", k), busy_v[k], e_busy);
        chk($sformatf("tx_done[%0d]", k), done_v[k], e_done);
    endtask

    task automatic refresh(input int k);
        empty[k] = (fq[k].size() == 0);
        fdat[k]  = (fq[k].size() != 0) ? fq[k][0] : 8'hEE;
    endtask

    task automatic push(input int k, input logic [7:0] v);
        fq[k].push_back(v);
        refresh(k);
    endtask

    // One clock: compare at the falling edge, then let the FIFOs react.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < NI; k++) model_cycle(k);
        rd_seen = rd_v;
        tr.push_back(tx_v[watch]);
        if (rd_v[watch]) rd_cnt++;
        if (done_v[watch]) done_idx.push_back(tr.size() - 1);
        @(posedge clk);
        #1;
        if (!rst) cyc++;
        for (int k = 0; k < NI; k++) begin
            if (rd_seen[k] && fq[k].size() != 0) void'(fq[k].pop_front());
            refresh(k);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic start_watch(input int k);
        watch = k;
        tr.delete();
        done_idx.delete();
        rd_cnt = 0;
    endtask

    function automatic logic sample(input int idx);
        if (idx < 0 || idx >= tr.size()) return 1'b1;
        return tr[idx];
    endfunction

    function automatic int first_low(input int from);
        for (int i = from; i >= 0 && i < tr.size(); i++) if (tr[i] == 1'b0) return i;
        return -1;
    endfunction

    function automatic int run_fwd(input int from, input logic v);
        int n = 0;
        for (int i = from; i >= 0 && i < tr.size() && tr[i] == v; i++) n++;
        return n;
    endfunction

    function automatic int run_back(input int from, input logic v);
        int n = 0;
        for (int i = from; i >= 0 && i < tr.size() && tr[i] == v; i--) n++;
        return n;
    endfunction

    // Receiver-style decode: sample each bit near its centre.
    function automatic int decode(input int i0, input int nb);
        int v = 0;
        for (int j = 0; j < nb; j++) if (sample(i0 + SAMP + BIT_C * j) == 1'b1) v = v | (1 << j);
        return v;
    endfunction

    function automatic int zeros();
        int n = 0;
        for (int i = 0; i < tr.size(); i++) if (tr[i] == 1'b0) n++;
        return n;
    endfunction

    int i0, s_len, d0, nxt;

    initial begin
        rst = 1'b1;
        for (int k = 0; k < NI; k++) refresh(k);
        model_clear();
        run(3);
        chk("reset_tx", tx_a, 1);
        chk("reset_busy", busy_a, 0);
        chk("reset_rd", rd_a, 0);
        chk("reset_done", done_a, 0);
        rst = 1'b0;
        cyc = 0;
        run(7);

        // 1: single 0xA5 frame, 8N1
        start_watch(0);
        push(0, 8'hA5);
        run(800);
        i0 = first_low(0);
        s_len = run_fwd(i0, 1'b0);
        chk("t1_fall_latency", i0, 1);
        chk("t1_start_in_61_64", (s_len >= 61 && s_len <= 64) ? 1 : 0, 1);
        chk("t1_byte", decode(i0, 8), 8'hA5);
        chk("t1_rd_pulses", rd_cnt, 1);
        chk("t1_done_pulses", done_idx.size(), 1);
        d0 = (done_idx.size() > 0) ? done_idx[0] : -1;
        chk("t1_data_stop_len", d0 - i0 - s_len, 9 * BIT_C);
        chk("t1_empty_after", empty[0], 1);

        // 2: back-to-back frames
        start_watch(0);
        push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h3C);
        run(2100);
        chk("t2_rd_pulses", rd_cnt, 3);
        chk("t2_done_pulses", done_idx.size(), 3);
        i0 = first_low(0);
        chk("t2_byte0", decode(i0, 8), 8'h00);
        d0 = (done_idx.size() > 0) ? done_idx[0] : -1;
        chk("t2_stop0_len", run_back(d0 - 1, 1'b1), BIT_C);
        chk("t2_idle0_high", sample(d0), 1);
        nxt = first_low(d0);
        chk("t2_gap0", nxt - d0, 1);
        chk("t2_byte1", decode(nxt, 8), 8'hFF);
        d0 = (done_idx.size() > 1) ? done_idx[1] : -1;
        nxt = first_low(d0);
        chk("t2_gap1", nxt - d0, 1);
        chk("t2_byte2", decode(nxt, 8), 8'h3C);

        // 3: parity, even then odd, on 0x07
        start_watch(1);
        push(1, 8'h07);
        run(800);
        i0 = first_low(0);
        s_len = run_fwd(i0, 1'b0);
        chk("t3_even_byte", decode(i0, 8), 8'h07);
        chk("t3_even_parity", sample(i0 + SAMP + BIT_C * 8), 1);
        d0 = (done_idx.size() > 0) ? done_idx[0] : -1;
        chk("t3_even_len", d0 - i0 - s_len, 10 * BIT_C);
        start_watch(2);
        push(2, 8'h07);
        run(800);
        i0 = first_low(0);
        s_len = run_fwd(i0, 1'b0);
        chk("t3_odd_parity", sample(i0 + SAMP + BIT_C * 8), 0);
        d0 = (done_idx.size() > 0) ? done_idx[0] : -1;
        chk("t3_odd_len", d0 - i0 - s_len, 10 * BIT_C);

        // 4: two stop bits on 0x55
        start_watch(3);
        push(3, 8'h55);
        run(900);
        i0 = first_low(0);
        chk("t4_byte", decode(i0, 8), 8'h55);
        chk("t4_done_pulses", done_idx.size(), 1);
        d0 = (done_idx.size() > 0) ? done_idx[0] : -1;
        chk("t4_stop_len", run_back(d0 - 1, 1'b1), 2 * BIT_C);

        // 5: reset in the middle of data bit 3 of 0x81 (that bit is 0)
        start_watch(0);
        push(0, 8'h81);
        run(290);
        chk("t5_bit3_low", tx_a, 0);
        rst = 1'b1;
        model_clear();
        #1;
        chk("t5_tx_immediate", tx_a, 1);
        chk("t5_busy_immediate", busy_a, 0);
        chk("t5_done_immediate", done_a, 0);
        run(5);
        rst = 1'b0;
        cyc = 0;
        start_watch(0);
        run(300);
        chk("t5_no_done", done_idx.size(), 0);
        chk("t5_no_rd", rd_cnt, 0);
        chk("t5_tx_high", zeros(), 0);

        // 6: long idle with the FIFO empty
        start_watch(0);
        run(1000);
        chk("t6_no_rd", rd_cnt, 0);
        chk("t6_tx_high", zeros(), 0);
        chk("t6_busy", busy_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
